serial_transmitter: RTL

//   Transmit end of the bit-serial byte link. Buffers parallel bytes from the

---
 rtl/serial_transmitter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/serial_transmitter.sv
// serial_transmitter: FIFO-buffered byte source that shifts each byte out
// MSB first as strobed bits, gated by a synchronized receiver-ready.
module serial_transmitter #(
    parameter int DEPTH             = 8,
    parameter int WRITE_HIGH_CYCLES = 10,
    parameter int WRITE_LOW_CYCLES  = 10,
    parameter int WORD_GAP_CYCLES   = 300
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enqueue_in,
    input  logic [7:0]                 data_in,
    input  logic                       status_in,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
    output logic                       serial_out,
    output logic                       write_out,
    output logic                       busy_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int HL_MAX = (WRITE_HIGH_CYCLES > WRITE_LOW_CYCLES) ?
                            WRITE_HIGH_CYCLES : WRITE_LOW_CYCLES;
    localparam int T_MAX = (HL_MAX > WORD_GAP_CYCLES) ?
                           HL_MAX : WORD_GAP_CYCLES;
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] HIGH_LAST = TW'(WRITE_HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LAST  = TW'(WRITE_LOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  =
        TW'((WORD_GAP_CYCLES > 0) ? WORD_GAP_CYCLES - 1 : 0);
    localparam bit GAP_EN = (WORD_GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE,
        BIT_HIGH,
        BIT_LOW,
        GAP
    } state_t;

    logic           sync_a;
    logic           status_s;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  len_next;
    logic           push;
    logic           pop;
    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_next;
    logic [2:0]     bit_cnt;
    logic [2:0]     bit_cnt_next;
    logic [7:0]     shreg;
    logic [7:0]     shreg_next;
    logic           serial_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a   <= 1'b0;
            status_s <= 1'b0;
        end else begin
            sync_a   <= status_in;
            status_s <= sync_a;
        end
    end

    // A full FIFO still accepts a byte when the head is popped this cycle.
    assign push = enqueue_in && (!full_out || pop);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_comb begin
        len_next = len_out;
        unique case ({push, pop})
            2'b10:   len_next = len_out + LW'(1);
            2'b01:   len_next = len_out - LW'(1);
            default: len_next = len_out;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len_out  <= '0;
            full_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            len_out  <= len_next;
            full_out <= (len_next == LW'(DEPTH));
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        serial_next  = serial_out;
        pop          = 1'b0;
        unique case (state)
            IDLE: begin
                if ((len_out != '0) && status_s) begin
                    pop          = 1'b1;
                    shreg_next   = mem[rd_ptr];
                    serial_next  = mem[rd_ptr][7];
                    bit_cnt_next = '0;
                    timer_next   = '0;
                    state_next   = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (timer == HIGH_LAST) begin
                    timer_next = '0;
                    state_next = BIT_LOW;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            BIT_LOW: begin
                if (timer == LOW_LAST) begin
                    timer_next   = '0;
                    shreg_next   = {shreg[6:0], 1'b0};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (GAP_EN) begin
                            state_next  = GAP;
                            serial_next = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next  = BIT_HIGH;
                        serial_next = shreg[6];
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            serial_out <= 1'b0;
            write_out  <= 1'b0;
            busy_out   <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            serial_out <= serial_next;
            write_out  <= (state_next == BIT_HIGH);
            busy_out   <= (state_next != IDLE);
        end
    end

endmodule
